// File: rtl/decode_stage.sv
// Decode stage: splits instruction fields, reads the integer register file and builds the
// sign-extended immediate, presenting the bundle to execute as one registered valid/ready stage.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] inst,
    input  logic [ILEN-1:0] pc_in,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] valA,
    output logic [XLEN-1:0] valB,
    output logic [XLEN-1:0] valC,
    output logic [ILEN-1:0] pc,
    output logic            decode_fault
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    function automatic logic is_supported(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_OP, OP_OPIMM, OP_LUI,
            OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH: is_supported = 1'b1;
            default:                              is_supported = 1'b0;
        endcase
    endfunction

    // Unsupported opcodes yield a zero immediate; the format is built at 32 bits, then sign-extended.
    function automatic logic signed [XLEN-1:0] imm_gen(input logic [31:0] i);
        logic signed [31:0] v;
        v = '0;
        case (i[6:0])
            OP_OPIMM, OP_LOAD, OP_JALR: v = {{20{i[31]}}, i[31:20]};
            OP_STORE:                   v = {{20{i[31]}}, i[31:25], i[11:7]};
            OP_BRANCH:                  v = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:           v = {i[31:12], 12'b0};
            OP_JAL:                     v = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default:                    v = '0;
        endcase
        imm_gen = XLEN'(v);
    endfunction

    logic [XLEN-1:0] r_regs [NREGS];

    logic            r_vld_p1;
    logic [6:0]      r_opcode_p1;
    logic [2:0]      r_func3_p1;
    logic [6:0]      r_func7_p1;
    logic [4:0]      r_rd_p1;
    logic [XLEN-1:0] r_vala_p1;
    logic [XLEN-1:0] r_valb_p1;
    logic [XLEN-1:0] r_valc_p1;
    logic [ILEN-1:0] r_pc_p1;
    logic            r_fault_p1;

    logic [4:0]      w_rs1_p0;
    logic [4:0]      w_rs2_p0;
    logic [XLEN-1:0] w_vala_p0;
    logic [XLEN-1:0] w_valb_p0;
    logic            w_fault_p0;
    logic            w_take_p0;

    assign w_rs1_p0 = inst[19:15];
    assign w_rs2_p0 = inst[24:20];

    // Same-edge writeback is forwarded so the captured bundle never sees a stale register.
    assign w_vala_p0 = (w_rs1_p0 == 5'd0)                   ? '0      :
                       (wb_en && (wb_rd == w_rs1_p0))       ? wb_data : r_regs[w_rs1_p0];
    assign w_valb_p0 = (w_rs2_p0 == 5'd0)                   ? '0      :
                       (wb_en && (wb_rd == w_rs2_p0))       ? wb_data : r_regs[w_rs2_p0];

    assign w_fault_p0 = (inst[1:0] != 2'b11) || !is_supported(inst[6:0]);
    assign in_ready   = !r_vld_p1 || out_ready;
    assign w_take_p0  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
        end else if (wb_en && (wb_rd != 5'd0)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // p0 -> p1: output register toward execute
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1    <= 1'b0;
            r_opcode_p1 <= '0;
            r_func3_p1  <= '0;
            r_func7_p1  <= '0;
            r_rd_p1     <= '0;
            r_vala_p1   <= '0;
            r_valb_p1   <= '0;
            r_valc_p1   <= '0;
            r_pc_p1     <= '0;
            r_fault_p1  <= 1'b0;
        end else if (flush) begin
            r_vld_p1 <= 1'b0;
        end else if (w_take_p0) begin
            r_vld_p1    <= 1'b1;
            r_opcode_p1 <= inst[6:0];
            r_func3_p1  <= inst[14:12];
            r_func7_p1  <= inst[31:25];
            r_rd_p1     <= inst[11:7];
            r_vala_p1   <= w_vala_p0;
            r_valb_p1   <= w_valb_p0;
            r_valc_p1   <= w_fault_p0 ? '0 : imm_gen(inst);
            r_pc_p1     <= pc_in;
            r_fault_p1  <= w_fault_p0;
        end else if (out_ready) begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign out_valid    = r_vld_p1;
    assign opcode       = r_opcode_p1;
    assign func3        = r_func3_p1;
    assign func7        = r_func7_p1;
    assign rd           = r_rd_p1;
    assign valA         = r_vala_p1;
    assign valB         = r_valb_p1;
    assign valC         = r_valc_p1;
    assign pc           = r_pc_p1;
    assign decode_fault = r_fault_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps plus random traffic, checked against a
// behavioural model holding the register file and the expected output bundle.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [31:0] pc_in;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rd;
    logic [31:0] valA;
    logic [31:0] valB;
    logic [31:0] valC;
    logic [31:0] pc;
    logic        decode_fault;

    int checks = 0;
    int errors = 0;

    // model state
    logic [31:0] m_regs [32];
    logic        m_vld;
    logic [31:0] m_inst;
    logic [31:0] m_a, m_b, m_c, m_pc;
    logic        m_fault;

    logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
                            7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011};

    decode_stage #(.XLEN(32), .ILEN(32), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc_in(pc_in), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .func3(func3), .func7(func7), .rd(rd), .valA(valA),
        .valB(valB), .valC(valC), .pc(pc), .decode_fault(decode_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic supported(input logic [31:0] i);
        supported = 1'b0;
        for (int k = 0; k < 9; k++) if (i[6:0] == ops[k]) supported = 1'b1;
    endfunction

    // Immediate computed arithmetically from the instruction word.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int s;
        s = int'(i);
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: ref_imm = 32'(s >>> 20);
            7'b0100011: ref_imm = 32'((s >>> 25) * 32 + int'(i[11:7]));
            7'b1100011: ref_imm = 32'((s >>> 31) * 4096 + int'(i[7]) * 2048
                                      + int'(i[30:25]) * 32 + int'(i[11:8]) * 2);
            7'b0110111, 7'b0010111: ref_imm = i & 32'hFFFF_F000;
            7'b1101111: ref_imm = 32'((s >>> 31) * (1 << 20) + int'(i[19:12]) * 4096
                                      + int'(i[20]) * 2048 + int'(i[30:21]) * 2);
            default: ref_imm = 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_regs[k] = '0;
        m_vld = 0; m_inst = '0; m_a = '0; m_b = '0; m_c = '0; m_pc = '0; m_fault = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
        chk({tag, ".fault"},     32'(decode_fault), 32'(m_fault));
        chk({tag, ".opcode"},    32'(opcode), 32'(m_inst[6:0]));
        chk({tag, ".func3"},     32'(func3), 32'(m_inst[14:12]));
        chk({tag, ".func7"},     32'(func7), 32'(m_inst[31:25]));
        chk({tag, ".rd"},        32'(rd), 32'(m_inst[11:7]));
        chk({tag, ".valA"},      valA, m_a);
        chk({tag, ".valB"},      valB, m_b);
        chk({tag, ".valC"},      valC, m_c);
        chk({tag, ".pc"},        pc, m_pc);
    endtask

    // Inputs are already driven; check in_ready, advance one edge, then compare.
    task automatic cycle(input string tag);
        logic rdy;
        #1;
        rdy = !m_vld || out_ready;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        // writeback applied first, so the read sees it (same-edge forwarding)
        if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
        if (flush) m_vld = 0;
        else if (in_valid && rdy) begin
            m_vld   = 1;
            m_inst  = inst;
            m_pc    = pc_in;
            m_a     = m_regs[inst[19:15]];
            m_b     = m_regs[inst[24:20]];
            m_fault = (inst[1:0] != 2'b11) || !supported(inst);
            m_c     = m_fault ? 32'h0 : ref_imm(inst);
        end else if (out_ready) m_vld = 0;
        @(posedge clk);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic ordy, input logic fl,
                         input logic we, input logic [4:0] wr, input logic [31:0] wd);
        in_valid = v; inst = i; pc_in = p; out_ready = ordy; flush = fl;
        wb_en = we; wb_rd = wr; wb_data = wd;
    endtask

    logic [31:0] held_c;

    initial begin
        model_reset();
        drive(0, 32'h0, 32'h0, 1, 0, 0, 5'd0, 32'h0);
        rst_n = 0;
        #12;
        check_outputs("reset");
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1;

        drive(0, 32'h0, 32'h0, 1, 0, 1, 5'd5, 32'h0000_1234);
        cycle("wr_x5");
        drive(1, 32'h0052_8313, 32'h100, 1, 0, 0, 5'd0, 32'h0);
        cycle("addi");
        chk("addi.valA_const", valA, 32'h1234);
        chk("addi.valC_const", valC, 32'd5);
        chk("addi.rd_const", 32'(rd), 32'd6);

        drive(1, 32'hFE00_0EE3, 32'h104, 1, 0, 0, 5'd0, 32'h0);
        cycle("beq");
        chk("beq.valC_const", valC, 32'hFFFF_FFFC);

        drive(1, 32'h0010_8133, 32'h108, 1, 0, 1, 5'd1, 32'hDEAD_BEEF);
        cycle("bypass");
        chk("bypass.valA_const", valA, 32'hDEAD_BEEF);
        chk("bypass.valB_const", valB, 32'hDEAD_BEEF);

        // stall with a pending instruction, then release
        held_c = valC;
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h0030_0293, 32'h10C, 0, 0, 1, 5'd1, 32'h5555_0000 + k);
            cycle("stall");
            chk("stall.in_ready_const", 32'(in_ready), 32'd0);
        end
        chk("stall.valA_held", valA, 32'hDEAD_BEEF);
        drive(1, 32'h0030_0293, 32'h10C, 1, 0, 0, 5'd0, 32'h0);
        cycle("release");
        chk("release.pc_const", pc, 32'h10C);

        drive(1, 32'h0000_0013, 32'h110, 1, 1, 0, 5'd0, 32'h0);
        cycle("flush");
        chk("flush.out_valid_const", 32'(out_valid), 32'd0);

        drive(0, 32'h0, 32'h0, 1, 0, 1, 5'd0, 32'hFFFF_FFFF);
        cycle("wr_x0");
        drive(1, 32'h0000_01B3, 32'h114, 1, 0, 0, 5'd0, 32'h0);
        cycle("rd_x0");
        chk("rd_x0.valA_const", valA, 32'h0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ri;
            ri = $urandom;
            if ($urandom_range(0, 3) != 0) ri[6:0] = ops[$urandom_range(0, 8)];
            drive($urandom_range(0, 3) != 0, ri, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 31)), $urandom);
            cycle("rand");
        end

        // fault bundle, stalled, then asynchronous reset
        drive(1, 32'h0000_007F, 32'h200, 1, 0, 0, 5'd0, 32'h0);
        cycle("fault");
        chk("fault.flag_const", 32'(decode_fault), 32'd1);
        chk("fault.valC_const", valC, 32'h0);
        drive(1, 32'h0000_0013, 32'h204, 0, 0, 0, 5'd0, 32'h0);
        cycle("fault_stall");
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk("async_rst.out_valid", 32'(out_valid), 32'd0);
        chk("async_rst.fault", 32'(decode_fault), 32'd0);
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1;
        drive(1, 32'h0022_8393, 32'h300, 1, 0, 0, 5'd0, 32'h0);
        cycle("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
